fifo_sync: RTL
==============

Name: fifo_sync

Overview:
- Single-clock, parametrised FIFO buffer with valid/ready handshakes on both sides, first-word-fall-through output, and a fill level with almost-full and almost-empty flags.
- Counts samples dropped while full, saturating.
- Sits between the print-mech sample capture logic and the host readout path, where the capture side cannot stall and lost samples must be reported.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits (>=1).
- DEPTH, 16, number of storage entries; power of two, >=2.
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when level >= this value (1..DEPTH).
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when level <= this value (0..DEPTH-1).
- DROP_COUNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents and level; does not clear drop_count or overflow.
- write_valid  in  1  producer has a word on write_data.
- write_ready  out  1  FIFO can accept a word this cycle.
- write_data  in  DATA_WIDTH  word to store.
- read_valid  out  1  read_data holds the oldest stored word.
- read_ready  in  1  consumer takes the word this cycle.
- read_data  out  DATA_WIDTH  head-of-FIFO word (FWFT).
- level  out  $clog2(DEPTH+1)  number of stored words, 0..DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL.
- overflow  out  1  sticky; set when a write is attempted while full.
- drop_count  out  DROP_COUNT_WIDTH  saturating count of words refused while full.
- clear_errors  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, write pointer and read pointer each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Storage contents are not reset. Only pointers, level and flags are reset.
- Reset (priority 1): next edge gives pointers=0, level=0, overflow=0, drop_count=0. Writes, reads and clear_errors in the same cycle are ignored.
- Flush (priority 2): pointers=0, level=0; overflow and drop_count are unchanged. Writes and reads in the same cycle are ignored, but a clear_errors in the same cycle still takes effect.
- Outputs after reset or flush: read_valid=0, write_ready=1, level=0, almost_empty=1, almost_full=0 (when ALMOST_FULL_LEVEL>=1).
- Combinational outputs (no registers):
  - write_ready = (level != DEPTH).
  - read_valid = (level != 0).
  - read_data = array[read pointer]. Its value when read_valid=0 is don't-care.
- Write transfer: write_valid && write_ready stores write_data at the write pointer and increments the pointer.
- Read transfer: read_valid && read_ready increments the read pointer.
- Level update:
  - +1 on a write only.
  - -1 on a read only.
  - Unchanged on a simultaneous write and read.
- Latency: a word written at edge N appears on read_data with read_valid=1 after edge N (cycle N+1). There is no same-cycle bypass.
- Empty with a simultaneous write_valid and read_ready: the write is accepted, no read occurs, level becomes 1.
- Full with a simultaneous write_valid and read_ready: the read occurs, the write is refused (write_ready=0), level becomes DEPTH-1.
  - The refused write counts as a drop and sets overflow.
  - Full means no pass-through.
- Drop accounting: each cycle with write_valid=1 and write_ready=0 (outside reset/flush) sets overflow=1 and increments drop_count, saturating at all-ones.
- clear_errors: overflow=0 and drop_count=0 at the next edge. A drop in the same cycle is lost, i.e. the clear wins.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. Full versus empty is resolved by level, not by pointer equality.
- Almost flags are derived combinationally from level.
- read_ready while empty has no effect; underflow is impossible by construction.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles with read_ready=0 -> level 1,2,3; read_valid rises the cycle after the first write; read_data=0x11.
- DEPTH=16: write 16 words 0x00..0x0F -> write_ready=0 and almost_full=1 from level 14. Drain all -> data 0x00..0x0F in order, read_valid=0 after the last read, almost_empty=1 at level<=2.
- Full FIFO, write_valid=1 with 0xAA and read_ready=1 for one cycle -> level 15, 0xAA not stored, overflow=1, drop_count=1.
- Hold write_valid=1 while full for 70000 cycles with DROP_COUNT_WIDTH=16 -> drop_count saturates at 0xFFFF. Then clear_errors=1 for one cycle -> overflow=0, drop_count=0.
- 40 interleaved writes and reads with DEPTH=16 (both pointers wrap twice), with simultaneous write+read at level 5 -> level stays 5 and output order matches input order exactly.
- Level 7, assert flush together with write_valid -> level 0, read_valid=0, overflow/drop_count unchanged. Assert reset mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with level, almost flags and saturating drop accounting.
// Latency: a word written at edge N is visible on read_data, with read_valid=1, from cycle N+1. There is no bypass.
// Backpressure: write_ready drops only when the FIFO is full. Refused writes are counted as drops and set the sticky overflow flag.
//
// Ports:
//   clk, reset         - sole clock; synchronous active-high reset
//   flush              - clears contents and level; keeps overflow/drop_count
//   write_valid/ready  - producer handshake; write_data is stored on a transfer
//   read_valid/ready   - consumer handshake; read_data is the head word
//   level              - number of stored words, 0..DEPTH
//   almost_full/empty  - thresholds on level
//   overflow           - sticky flag, set by a write attempted while full
//   drop_count         - saturating count of refused words
//   clear_errors       - clears overflow and drop_count
module fifo_sync #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int DROP_COUNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          write_valid,
  output logic                          write_ready,
  input  logic [DATA_WIDTH-1:0]         write_data,
  output logic                          read_valid,
  input  logic                          read_ready,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic [DROP_COUNT_WIDTH-1:0]   drop_count,
  input  logic                          clear_errors
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;

  logic do_write;
  logic do_read;
  logic drop;

  // Full/empty come from the level counter, so pointer equality is never ambiguous.
  assign write_ready  = (level_q != LVL_W'(DEPTH));
  assign read_valid   = (level_q != '0);
  assign read_data    = mem[rd_ptr];
  assign level        = level_q;
  assign almost_full  = (level_q >= LVL_W'(ALMOST_FULL_LEVEL));
  assign almost_empty = (level_q <= LVL_W'(ALMOST_EMPTY_LEVEL));

  // When full, write_ready is low, so a simultaneous read never lets a write through.
  assign do_write = write_valid && write_ready;
  assign do_read  = read_valid && read_ready;
  assign drop     = write_valid && !write_ready;

  // Storage has no reset; only words inside the valid window are ever observed.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_write) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !do_read) begin
        level_q <= level_q + 1'b1;
      end else if (do_read && !do_write) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Error accounting survives flush; clear_errors beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (reset || clear_errors) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (!flush && drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
